// File: rtl/sigmoid_arb_if.sv
// Request, PLA and response signals of the shared sigmoid arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface sigmoid_arb_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_x;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      pla_x;
  logic [WIDTH-1:0]      pla_y;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_y;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;

  modport master (
    output req_valid, req_x, pla_y, rsp_ready,
    input  req_ready, pla_x, rsp_valid, rsp_y, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_x, pla_y, rsp_ready,
    output req_ready, pla_x, rsp_valid, rsp_y, rsp_id, busy
  );
endinterface

// File: rtl/sigmoid_arb.sv
// Round-robin arbiter sharing one fixed-latency sigmoid PLA pipeline among NREQ
// requesters; results are tagged with the requester id and returned in issue order.
module sigmoid_arb #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int LAT   = 4,
  parameter int DEPTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  sigmoid_arb_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  logic [IDW-1:0]          ptr;
  logic [CW-1:0]           outstanding;
  logic [CW-1:0]           count;
  logic                    credit;
  logic                    fire;
  logic [NREQ-1:0]         grant;
  logic [IDW-1:0]          grant_id;
  logic [IDW-1:0]          cand;
  logic signed [WIDTH-1:0] granted_x;

  logic [LAT-1:0]          tag_vld_p;
  logic [IDW-1:0]          tag_id_p [LAT];

  logic [WIDTH-1:0]        mem_y  [DEPTH];
  logic [IDW-1:0]          mem_id [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic                    push;
  logic                    pop;

  // Outstanding credit covers both in-flight and buffered results, so the FIFO cannot overflow.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    fire     = 1'b0;
    cand     = '0;
    credit   = rst_n && (outstanding != CW'(DEPTH));
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + IDW'(k);
      if (credit && !fire && bus.req_valid[cand]) begin
        grant[cand] = 1'b1;
        grant_id    = cand;
        fire        = 1'b1;
      end
    end
  end

  always_comb begin
    granted_x = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) granted_x = bus.req_x[i*WIDTH +: WIDTH];
    end
  end

  assign bus.req_ready = grant;
  assign bus.pla_x     = granted_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (fire) begin
      ptr <= grant_id + IDW'(1);
    end
  end

  // Tag pipeline p0..p(LAT-1) tracks the PLA pipeline stage for stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_p <= '0;
      for (int s = 0; s < LAT; s++) tag_id_p[s] <= '0;
    end else begin
      tag_vld_p[0] <= fire;
      tag_id_p[0]  <= fire ? grant_id : '0;
      for (int s = 1; s < LAT; s++) begin
        tag_vld_p[s] <= tag_vld_p[s-1];
        tag_id_p[s]  <= tag_id_p[s-1];
      end
    end
  end

  assign push = tag_vld_p[LAT-1];
  assign pop  = bus.rsp_valid && bus.rsp_ready;

  // Result FIFO: PLA output lands here at the end of the last tag stage.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_y[wr_ptr]  <= bus.pla_y;
      mem_id[wr_ptr] <= tag_id_p[LAT-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case ({fire, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign bus.rsp_valid = (count != '0);
  assign bus.rsp_y     = bus.rsp_valid ? mem_y[rd_ptr]  : '0;
  assign bus.rsp_id    = bus.rsp_valid ? mem_id[rd_ptr] : '0;
  assign bus.busy      = (outstanding != '0);

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count == CW'(DEPTH)));

endmodule
